// File: rtl/sfx_pkg.sv
// Shared definitions for the sound-effect sweep engine.
//   DIR_DOWN_HP / DIR_UP_HP : meaning of the per-channel dir bit
//   sfx_state_t             : sweep FSM state encoding
//   clog2_min1              : $clog2 that never returns less than 1 (port widths)
package sfx_pkg;

  // dir = 0: half-period shrinks (pitch rises); dir = 1: half-period grows (pitch falls)
  localparam logic DIR_DOWN_HP = 1'b0;
  localparam logic DIR_UP_HP   = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } sfx_state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sfx_pwm.sv
// Volume PWM stage for the sweep engine.
// A free-running counter (cleared only by reset) is compared against vol; the
// square wave is gated by that duty and by mute, then registered onto the pin.
// Ports:
//   CLK100MHZ  in   system clock
//   reset      in   synchronous active-high reset
//   sq         in   square wave from the sweep datapath
//   vol        in   duty numerator, vol / 2^PWM_W
//   mute       in   forces audio_out low
//   audio_out  out  registered PWM audio output (one cycle behind sq)
module sfx_pwm #(
  parameter int PWM_W = 4
) (
  input  logic             CLK100MHZ,
  input  logic             reset,
  input  logic             sq,
  input  logic [PWM_W-1:0] vol,
  input  logic             mute,
  output logic             audio_out
);

  logic [PWM_W-1:0] pwm_cnt;

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      pwm_cnt   <= '0;
      audio_out <= 1'b0;
    end else begin
      // wraps naturally modulo 2^PWM_W
      pwm_cnt   <= pwm_cnt + PWM_W'(1);
      audio_out <= sq & ~mute & (pwm_cnt < vol);
    end
  end

endmodule

// File: rtl/sfx_sweep_engine.sv
// Multi-channel square-wave pitch-sweep sound-effect generator.
// The highest-index triggered channel (with non-zero len) wins; a winner with
// an index >= the playing channel restarts the sweep, a lower one is ignored.
// Each toggle of the square wave moves the half-period by step (clamped to
// [MIN_HP, 2^CNT_W-1]) until len toggles have been produced.
// Ports:
//   CLK100MHZ  in   system clock
//   reset      in   synchronous active-high reset
//   trig       in   one-cycle start pulse per channel (higher index wins)
//   start_hp   in   per-channel initial half-period, channel c at [c*CNT_W +: CNT_W]
//   step       in   per-channel half-period change per toggle
//   dir        in   per-channel sweep direction (see sfx_pkg)
//   len        in   per-channel number of toggles, channel c at [c*LEN_W +: LEN_W]
//   vol        in   output duty while the square wave is high
//   mute       in   silences audio_out, sweep keeps running
//   audio_out  out  registered PWM audio output
//   busy       out  high while a sweep plays
//   active_ch  out  channel playing (holds last value when idle)
//   done       out  one-cycle pulse on natural completion of a sweep
module sfx_sweep_engine
  import sfx_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 24,
  parameter int LEN_W  = 8,
  parameter int PWM_W  = 4,
  parameter int MIN_HP = 2,
  parameter int CH_W   = clog2_min1(NUM_CH)
) (
  input  logic                    CLK100MHZ,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       trig,
  input  logic [NUM_CH*CNT_W-1:0] start_hp,
  input  logic [NUM_CH*CNT_W-1:0] step,
  input  logic [NUM_CH-1:0]       dir,
  input  logic [NUM_CH*LEN_W-1:0] len,
  input  logic [PWM_W-1:0]        vol,
  input  logic                    mute,
  output logic                    audio_out,
  output logic                    busy,
  output logic [CH_W-1:0]         active_ch,
  output logic                    done
);

  localparam logic [CNT_W-1:0] MIN_HP_V = CNT_W'(MIN_HP);

  sfx_state_t state_q, state_d;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hp;
  logic [CNT_W-1:0] step_q;
  logic             dir_q;
  logic [LEN_W-1:0] toggles_left;
  logic             sq;

  // ---------------- priority select ----------------
  logic             win_vld;
  logic [CH_W-1:0]  win_idx;
  logic [CNT_W-1:0] sel_start;
  logic [CNT_W-1:0] sel_step;
  logic             sel_dir;
  logic [LEN_W-1:0] sel_len;

  // Ascending scan: the last qualifying channel (highest index) wins.
  always_comb begin
    win_vld   = 1'b0;
    win_idx   = '0;
    sel_start = '0;
    sel_step  = '0;
    sel_dir   = DIR_DOWN_HP;
    sel_len   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (trig[c] && (len[c*LEN_W +: LEN_W] != '0)) begin
        win_vld   = 1'b1;
        win_idx   = CH_W'(c);
        sel_start = start_hp[c*CNT_W +: CNT_W];
        sel_step  = step[c*CNT_W +: CNT_W];
        sel_dir   = dir[c];
        sel_len   = len[c*LEN_W +: LEN_W];
      end
    end
  end

  // ---------------- FSM ----------------
  logic start_go;
  logic seg_end;
  logic finish;

  always_comb begin
    start_go = win_vld && ((state_q == ST_IDLE) || (win_idx >= active_ch));
    seg_end  = (state_q == ST_PLAY) && (cnt == hp - CNT_W'(1));
    finish   = seg_end && (toggles_left == LEN_W'(1));
    state_d  = state_q;
    if (start_go) begin
      state_d = ST_PLAY;   // a start on the completion edge wins over finishing
    end else if (finish) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  assign busy = (state_q == ST_PLAY);

  // ---------------- half-period update ----------------
  // Both paths work one bit wider so saturation is decided before any wrap.
  logic [CNT_W:0]   hp_sum;
  logic [CNT_W:0]   hp_floor;
  logic [CNT_W-1:0] hp_next;

  always_comb begin
    hp_sum   = {1'b0, hp} + {1'b0, step_q};
    hp_floor = {1'b0, step_q} + {1'b0, MIN_HP_V};
    if (dir_q == DIR_UP_HP) begin
      hp_next = hp_sum[CNT_W] ? '1 : hp_sum[CNT_W-1:0];
    end else begin
      hp_next = ({1'b0, hp} < hp_floor) ? MIN_HP_V : (hp - step_q);
    end
  end

  // ---------------- sweep datapath ----------------
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      cnt          <= '0;
      hp           <= '0;
      step_q       <= '0;
      dir_q        <= DIR_DOWN_HP;
      toggles_left <= '0;
      sq           <= 1'b0;
      active_ch    <= '0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_go) begin
        hp           <= (sel_start < MIN_HP_V) ? MIN_HP_V : sel_start;
        step_q       <= sel_step;
        dir_q        <= sel_dir;
        toggles_left <= sel_len;
        cnt          <= '0;
        sq           <= 1'b1;
        active_ch    <= win_idx;
      end else if (state_q == ST_PLAY) begin
        if (seg_end) begin
          cnt          <= '0;
          toggles_left <= toggles_left - LEN_W'(1);
          hp           <= hp_next;
          if (finish) begin
            sq   <= 1'b0;
            done <= 1'b1;
          end else begin
            sq <= ~sq;
          end
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  // ---------------- volume PWM ----------------
  sfx_pwm #(
    .PWM_W(PWM_W)
  ) u_pwm (
    .CLK100MHZ(CLK100MHZ),
    .reset    (reset),
    .sq       (sq),
    .vol      (vol),
    .mute     (mute),
    .audio_out(audio_out)
  );

endmodule
